// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and configuration check for the chunked serial adder
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  function automatic bit cfg_ok(int width, int chunk);
    return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational ripple add of two CHUNK-bit slices with carry in
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic w_c;

  // o_c_msb ends up as the carry into the slice's top bit, needed for signed overflow
  always_comb begin
    o_sum   = '0;
    w_c     = i_cin;
    o_c_msb = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_c_msb  = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle CHUNK-per-clock adder; subtract mode under SUBTRACT_EN
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam bit CFG_OK = cfg_ok(WIDTH, CHUNK);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("chunked_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
  end

  add_state_t       r_state;
  add_state_t       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_chunk_c_msb;
  logic             w_last;

`ifdef SUBTRACT_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_last    = (r_idx == LAST_IDX);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .i_a     (w_a_chunk),
    .i_b     (w_b_chunk),
    .i_cin   (r_carry),
    .o_sum   (w_chunk_sum),
    .o_cout  (w_chunk_cout),
    .o_c_msb (w_chunk_c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // On the final chunk the slice carries are the word's MSB carries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_chunk_sum;
          r_carry <= w_chunk_cout;
          if (w_last) begin
            r_cout <= w_chunk_cout;
            r_ovf  <= w_chunk_c_msb ^ w_chunk_cout;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - scoreboard bench for chunked_serial_adder (8/2 and 16/16)
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready, cin;
  logic [7:0] a, b;
  logic       in_ready, out_valid, cout, ovf;
  logic [7:0] sum;
`ifdef SUBTRACT_EN
  logic       sub;
`endif

  logic        in_valid2, cin2;
  logic [15:0] a2, b2;
  logic        in_ready2, out_valid2, cout2, ovf2;
  logic [15:0] sum2;

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2),
`ifdef SUBTRACT_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid2), .out_ready(1'b1),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result8: sum 0x%0h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("sum8", 32'(sum), 32'(e.s[7:0]));
        chk("cout8", 32'(cout), 32'(e.c));
        chk("ovf8", 32'(ovf), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result16: sum 0x%0h with empty scoreboard", sum2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("sum16", 32'(sum2), 32'(e.s));
        chk("cout16", 32'(cout2), 32'(e.c));
        chk("ovf16", 32'(ovf2), 32'(e.o));
      end
    end
  end

  task automatic wait_drop1();
    int n = 0;
    while (out_valid && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_release8", 32'(out_valid), 32'd0);
  endtask

  task automatic launch1(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         input logic si, input logic [7:0] es, input logic ec,
                         input logic eo, input int hold);
    int lat = 0;
    q1.push_back('{s: {8'h00, es}, c: ec, o: eo});
    a = ai; b = bi; cin = ci;
`ifdef SUBTRACT_EN
    sub = si;
`else
    if (si) $display("note: subtract vector issued without subtract support");
`endif
    if (hold > 0) out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency8", 32'(lat), 32'd4);
    if (hold > 0) begin
      a = 8'h11; b = 8'h22; cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_sum", 32'(sum), 32'(es));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    wait_drop1();
  endtask

  task automatic op1(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     input logic [7:0] es, input logic ec, input logic eo);
    launch1(ai, bi, ci, 1'b0, es, ec, eo, 0);
  endtask

  task automatic op2(input logic [15:0] ai, input logic [15:0] bi, input logic ci);
    logic [16:0] t;
    int lat = 0;
    t = {1'b0, ai} + {1'b0, bi} + 17'(ci);
    q2.push_back('{s: t[15:0], c: t[16], o: (ai[15] == bi[15]) && (t[15] != ai[15])});
    a2 = ai; b2 = bi; cin2 = ci; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    while (!out_valid2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency16", 32'(lat), 32'd1);
    @(posedge clk); #1;
    chk("in_ready16", 32'(in_ready2), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; a = '0; b = '0;
`ifdef SUBTRACT_EN
    sub = 1'b0;
`endif
    in_valid2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    op1(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op1(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op1(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op1(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    op1(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    chk("idle_hold_sum", 32'(sum), 32'h01);

    launch1(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 10);
    op1(8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 1'b0);

    // abort after two RUN chunks; partial sum must not survive
    a = 8'hFF; b = 8'h00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    op1(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    launch1(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    launch1(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 0);
    launch1(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    sub = 1'b0;
`endif

    op2(16'hFFFF, 16'h0000, 1'b1);
    op2(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op2(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard8_empty", 32'(q1.size()), 32'd0);
    chk("scoreboard16_empty", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
